// File: rtl/spi_master.sv
// SPI mode-0 master: one 24-bit frame per start, preamble SCLK pulse, framed by cs_n.
// cs_n timing is programmable by setup/hold/idle cycle counts.
module spi_master #(
    parameter int CLK_DIV      = 3,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int CS_IDLE_CYC  = 8
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] i_tx_frame,
    output logic        busy,
    output logic        done,
    output logic [23:0] o_rx_frame,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP_CYC - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD_CYC - 1);
    localparam logic [7:0] IDLE_M1  = 8'(CS_IDLE_CYC - 1);
    localparam logic [4:0] NPULSE   = 5'd25;

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_IDLE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  pulse;
    logic [23:0] tx_sh;
    logic [23:0] rx_sh;
    logic        miso_m, miso_s;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pulse      <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            miso_m     <= 1'b0;
            miso_s     <= 1'b0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            o_rx_frame <= '0;
        end else begin
            miso_m <= miso;
            miso_s <= miso_m;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh <= i_tx_frame;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                        mosi  <= 1'b0;
                        cnt   <= '0;
                        state <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == SETUP_M1) begin
                        cnt   <= '0;
                        pulse <= '0;
                        rx_sh <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    // First SHIFT cycle launches the preamble pulse high phase.
                    if (pulse == 5'd0) begin
                        sclk  <= 1'b1;
                        pulse <= 5'd1;
                        cnt   <= '0;
                    end else if (cnt == DIV_M1) begin
                        cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (pulse == NPULSE) begin
                                mosi <= 1'b0;
                            end else begin
                                mosi  <= tx_sh[23];
                                tx_sh <= {tx_sh[22:0], 1'b0};
                            end
                        end else if (pulse == NPULSE) begin
                            state <= CS_HOLD;
                        end else begin
                            // Rise of pulses 2..25 samples the synchronised miso.
                            sclk  <= 1'b1;
                            pulse <= pulse + 5'd1;
                            rx_sh <= {rx_sh[22:0], miso_s};
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CS_HOLD: begin
                    if (cnt == HOLD_M1) begin
                        cs_n       <= 1'b1;
                        o_rx_frame <= rx_sh;
                        done       <= 1'b1;
                        cnt        <= '0;
                        state      <= CS_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CS_IDLE: begin
                    if (cnt == IDLE_M1) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: slave/miso model on a default instance,
// SCLK phase and cs_n timing monitor on a CLK_DIV=2 instance.
module tb_spi_master;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        start2 = 1'b0;
    logic [23:0] tx     = '0;
    logic        miso   = 1'b0;
    logic        busy, done, sclk, cs_n, mosi;
    logic [23:0] rx;
    logic        busy2, done2, sclk2, cs_n2, mosi2;
    logic [23:0] rx2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    spi_master dut (
        .sysclk(sysclk), .rst_n(rst_n), .start(start), .i_tx_frame(tx),
        .busy(busy), .done(done), .o_rx_frame(rx),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(2)) dut2 (
        .sysclk(sysclk), .rst_n(rst_n), .start(start2), .i_tx_frame(tx),
        .busy(busy2), .done(done2), .o_rx_frame(rx2),
        .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave model / monitor for the default instance
    logic        sclk_p = 1'b0, cs_p = 1'b1;
    int          rises = 0, falls = 0, frames = 0, done_cnt = 0, done_cyc = 0;
    int          cs_hi_len = 0, last_cs_hi = 0;
    logic [23:0] slv_rx = '0, miso_pat = '0;

    always @(negedge sysclk) begin
        if (!cs_n && cs_p) begin
            rises      <= 0;
            falls      <= 0;
            frames     <= frames + 1;
            last_cs_hi <= cs_hi_len;
        end else if (sclk && !sclk_p) begin
            rises <= rises + 1;
            if (rises >= 1) slv_rx <= {slv_rx[22:0], mosi};
        end else if (!sclk && sclk_p) begin
            falls <= falls + 1;
            miso  <= (falls < 24) ? miso_pat[23 - falls] : 1'b0;
        end
        cs_hi_len <= cs_n ? cs_hi_len + 1 : 0;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        sclk_p <= sclk;
        cs_p   <= cs_n;
    end

    // phase-length monitor for the CLK_DIV=2 instance
    logic s2p = 1'b0, cs2p = 1'b1;
    int   run2 = 0, rises2 = 0, hi_bad = 0, lo_bad = 0, cs_low2 = 0, done2_cnt = 0;

    always @(negedge sysclk) begin
        if (sclk2 != s2p) begin
            if (s2p) begin
                if (run2 != 2) hi_bad <= hi_bad + 1;
            end else begin
                if (rises2 != 0 && run2 != 2) lo_bad <= lo_bad + 1;
                rises2 <= rises2 + 1;
            end
            run2 <= 1;
        end else begin
            run2 <= run2 + 1;
        end
        if (!cs_n2) cs_low2 <= cs2p ? 1 : cs_low2 + 1;
        if (done2) done2_cnt <= done2_cnt + 1;
        s2p  <= sclk2;
        cs2p <= cs_n2;
    end

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < 2000) begin
            @(negedge sysclk);
            k++;
        end
        chk("done_wait", done_cnt, n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 2000) begin
            @(negedge sysclk);
            k++;
        end
        chk("idle_wait", busy, 0);
    endtask

    int acc_cyc;

    initial begin
        // reset with start already high; first frame must be accepted right after release
        tx       = 24'h01_05_80;
        miso_pat = 24'hA5_3C_0F;
        start    = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx, 0);
        rst_n = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        acc_cyc = cyc;
        start   = 1'b0;
        chk("acc_cs_n", cs_n, 0);
        chk("acc_busy", busy, 1);
        wait_done(1);
        chk("latency", done_cyc - acc_cyc, 159);
        chk("slave_rx1", slv_rx, 24'h01_05_80);
        chk("rx_frame1", rx, 24'hA5_3C_0F);
        chk("post_mosi", mosi, 0);

        // start/tx changes while busy must not disturb the frame in flight
        wait_idle();
        tx       = 24'hC3_5A_96;
        miso_pat = 24'h5A_C3_81;
        start    = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start = 1'b0;
        repeat (40) @(negedge sysclk);
        tx    = 24'hFF_FF_FF;
        start = 1'b1;
        repeat (2) @(negedge sysclk);
        start = 1'b0;
        wait_done(2);
        chk("slave_rx2", slv_rx, 24'hC3_5A_96);
        chk("rx_frame2", rx, 24'h5A_C3_81);
        repeat (60) @(negedge sysclk);
        chk("no_queue", frames, 2);
        chk("idle_busy", busy, 0);

        // back-to-back frames with start held high
        tx       = 24'h12_34_56;
        miso_pat = 24'h0F_F0_55;
        start    = 1'b1;
        wait_done(3);
        chk("b2b_rx3", rx, 24'h0F_F0_55);
        wait_done(4);
        chk("gap_4", last_cs_hi, 9);
        chk("b2b_slave", slv_rx, 24'h12_34_56);
        wait_done(5);
        start = 1'b0;
        chk("gap_5", last_cs_hi, 9);
        repeat (40) @(negedge sysclk);
        chk("b2b_frames", frames, 5);

        // reset during pulse 12 aborts the frame
        wait_idle();
        start = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start = 1'b0;
        begin
            int k = 0;
            while (rises != 12 && k < 500) begin
                @(negedge sysclk);
                k++;
            end
        end
        chk("pulse12_wait", rises, 12);
        rst_n = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rx", rx, 0);
        repeat (250) @(negedge sysclk);
        chk("abort_nodone", done_cnt, 5);

        // CLK_DIV=2 instance: phase lengths, pulse count, cs_n low window
        start2 = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start2 = 1'b0;
        begin
            int k = 0;
            while (done2_cnt < 1 && k < 1000) begin
                @(negedge sysclk);
                k++;
            end
        end
        chk("div2_done", done2_cnt, 1);
        chk("div2_pulses", rises2, 25);
        chk("div2_hi_bad", hi_bad, 0);
        chk("div2_lo_bad", lo_bad, 0);
        chk("div2_cs_low", cs_low2, 109);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
